multicycle_sequencer: RTL
=========================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 clock  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 run  in  1  level; 1 = execute instructions, 0 = park in IDLE after the current instruction.
REQ-004 opcode  in  3  IR[7:5]; valid from DECODE onward (000 R, 001 MFI, 010 MW, 011 MR, 100 J, 101 JCE, 110 MB, 111 JCN).
REQ-005 eq  in  1  datapath equality flag; sampled in EXEC only.
REQ-006 mem_ready  in  1  memory completes the current mem_rd/mem_wr this cycle.
REQ-007 in_valid  in  1  input device holds valid data this cycle.
REQ-008 ir_load, pc_inc, pc_load  out  1 each  IR load, PC+1, PC<-target strobes.
REQ-009 mem_rd, mem_wr, addr_sel  out  1 each  memory read, write, address select (0 = PC, 1 = data address).
REQ-010 reg_wr  out  1  register-file write strobe.
REQ-011 wb_sel  out  2  write-back source: 00 ALU, 01 MEM, 10 IMM, 11 IN.
REQ-012 in_req  out  1  input request to the device.
REQ-013 busy  out  1  state != IDLE.
REQ-014 state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, IOWAIT=6; 7 unused.
REQ-015 instret  out  16  retired-instruction counter.

Function
REQ-016 State SHALL be registered; strobe outputs SHALL be combinational decodes of state, opcode and handshake inputs; every strobe not listed for a state SHALL be 0, and wb_sel SHALL be 00 unless stated otherwise.
REQ-017 IDLE: no strobes; go to FETCH when run=1.
REQ-018 FETCH: mem_rd=1, addr_sel=0; while mem_ready=0, hold FETCH; on the mem_ready=1 cycle, ir_load=1 and pc_inc=1, next DECODE.
REQ-019 DECODE: no strobes; next EXEC unconditionally.
REQ-020 EXEC routing: R, MB -> WB; MW, MR -> MEM; MFI -> IOWAIT; J, JCE, JCN complete in EXEC.
REQ-021 EXEC jumps: pc_load=1 for J; pc_load=eq for JCE; pc_load=!eq for JCN; pc_inc=0.
REQ-022 MEM: addr_sel=1; MW drives mem_wr=1 and completes on mem_ready=1; MR drives mem_rd=1 and goes to WB on mem_ready=1; mem_ready=0 holds MEM.
REQ-023 WB: reg_wr=1 for exactly one cycle; wb_sel = 00 for R, 01 for MR, 10 for MB; completes.
REQ-024 IOWAIT: in_req=1; on in_valid=1, reg_wr=1 and wb_sel=11 in the same cycle and complete; in_valid=0 holds IOWAIT with no timeout.
REQ-025 Completion cycle: instret increments by 1, wrapping FFFF->0000; next state is FETCH if run=1, else IDLE.
REQ-026 run=0 mid-instruction SHALL NOT abort it; it takes effect only at completion.
REQ-027 Minimum latency FETCH-entry to completion, with zero wait: jumps 3 cycles; R, MB, MW, MFI 4; MR 5; each wait cycle adds 1.
REQ-028 mem_ready or in_valid asserted in a state that does not consume it SHALL be ignored.
REQ-029 Unused state 7 SHALL go to IDLE on the next edge with no strobes.

Reset
REQ-030 reset=1 SHALL force state=IDLE and instret=0 on the next edge, overriding run and any pending handshake, including mid-MEM or mid-IOWAIT.
REQ-031 While reset=1 and in the cycle after release, all strobes SHALL be 0 and busy=0.

Verification
REQ-032 reset, run=1, opcode=000, mem_ready=1, in_valid=0 -> states 1,2,3,5; reg_wr=1 with wb_sel=00 in the 4th cycle; instret=1.
REQ-033 MR with mem_ready low for 2 cycles in FETCH and 1 cycle in MEM -> MR takes 8 cycles; then WB with wb_sel=01; mem_rd=1 and addr_sel=1 throughout MEM.
REQ-034 JCE with eq=1 -> pc_load=1 in EXEC; JCN with eq=1 -> pc_load=0; 3 cycles each, instret +2 total.
REQ-035 MFI with in_valid low for 5 cycles -> in_req held 5 cycles; then reg_wr=1 and wb_sel=11 coincide with in_valid; no extra cycle.
REQ-036 run dropped during MEM of MW -> MW completes and state goes to IDLE; reset asserted during IOWAIT -> state=0, instret=0 next edge.
REQ-037 Preload 65535 retirements -> the next completion wraps instret to 0.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: memory and input-device handshake between the sequencer and its peers
//   master (sequencer): drives mem_rd, mem_wr, addr_sel, in_req; samples mem_ready, in_valid
//   slave  (memory/io): samples the strobes; drives mem_ready, in_valid
interface multicycle_sequencer_if;
    logic mem_rd;
    logic mem_wr;
    logic addr_sel;
    logic mem_ready;
    logic in_req;
    logic in_valid;
    modport master (output mem_rd, mem_wr, addr_sel, in_req, input mem_ready, in_valid);
    modport slave  (input mem_rd, mem_wr, addr_sel, in_req, output mem_ready, in_valid);
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FSM sequencing fetch/decode/exec/mem/wb/io-wait for an 8-opcode CPU
//   clock, reset : rising-edge clock, synchronous active-high reset
//   run          : 1 = keep executing, 0 = park in IDLE at the next completion
//   opcode, eq   : IR[7:5] and datapath equality flag
//   bus          : memory read/write/address-select and input-device handshake
//   ir_load, pc_inc, pc_load, reg_wr, wb_sel : datapath strobes
//   busy, state, instret : status and retired-instruction count
module multicycle_sequencer (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [2:0]            opcode,
    input  logic                  eq,
    multicycle_sequencer_if.master bus,
    output logic                  ir_load,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic                  reg_wr,
    output logic [1:0]            wb_sel,
    output logic                  busy,
    output logic [2:0]            state,
    output logic [15:0]           instret
);
    localparam logic [2:0] OP_R   = 3'b000;
    localparam logic [2:0] OP_MFI = 3'b001;
    localparam logic [2:0] OP_MW  = 3'b010;
    localparam logic [2:0] OP_MR  = 3'b011;
    localparam logic [2:0] OP_J   = 3'b100;
    localparam logic [2:0] OP_JCE = 3'b101;
    localparam logic [2:0] OP_MB  = 3'b110;
    localparam logic [2:0] OP_JCN = 3'b111;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, IOWAIT, UNUSED} state_t;

    state_t      state_q, state_d;
    logic [15:0] instret_q, instret_d;
    logic        done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        instret_d    = instret_q;
        done         = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        reg_wr       = 1'b0;
        wb_sel       = 2'b00;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.addr_sel = 1'b0;
        bus.in_req   = 1'b0;
        case (state_q)
            IDLE:   state_d = run ? FETCH : IDLE;
            FETCH: begin
                bus.mem_rd = 1'b1;
                ir_load    = bus.mem_ready;
                pc_inc     = bus.mem_ready;
                state_d    = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                state_d = (opcode == OP_R  || opcode == OP_MB) ? WB :
                          (opcode == OP_MW || opcode == OP_MR) ? MEM :
                          (opcode == OP_MFI)                   ? IOWAIT : EXEC;
                pc_load = (opcode == OP_J)   ? 1'b1 :
                          (opcode == OP_JCE) ? eq :
                          (opcode == OP_JCN) ? !eq : 1'b0;
                done    = opcode == OP_J || opcode == OP_JCE || opcode == OP_JCN;
            end
            MEM: begin
                bus.addr_sel = 1'b1;
                bus.mem_wr   = opcode == OP_MW;
                bus.mem_rd   = opcode != OP_MW;
                done         = opcode == OP_MW && bus.mem_ready;
                state_d      = (opcode != OP_MW && bus.mem_ready) ? WB : MEM;
            end
            WB: begin
                reg_wr = 1'b1;
                wb_sel = (opcode == OP_MR) ? 2'b01 : (opcode == OP_MB) ? 2'b10 : 2'b00;
                done   = 1'b1;
            end
            IOWAIT: begin
                bus.in_req = 1'b1;
                reg_wr     = bus.in_valid;
                wb_sel     = bus.in_valid ? 2'b11 : 2'b00;
                done       = bus.in_valid;
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d   = run ? FETCH : IDLE;
            instret_d = instret_q + 16'd1;
        end
        // state may still be stale during the first reset cycle, so quiet every strobe
        if (reset) begin
            ir_load      = 1'b0;
            pc_inc       = 1'b0;
            pc_load      = 1'b0;
            reg_wr       = 1'b0;
            wb_sel       = 2'b00;
            bus.mem_rd   = 1'b0;
            bus.mem_wr   = 1'b0;
            bus.addr_sel = 1'b0;
            bus.in_req   = 1'b0;
        end
    end

    assign busy    = state_q != IDLE && !reset;
    assign state   = state_q;
    assign instret = instret_q;
endmodule
